// File: rtl/lf_adder_pipe.sv
// Pipelined Ladner-Fischer prefix adder with an optional OR-approximated low segment.
// An exact sum is computed alongside the delivered one to flag approximation error.
module lf_adder_pipe #(
  parameter int unsigned N           = 16,
  parameter int unsigned K           = 4,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         approx_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         out_diff
);

  localparam int unsigned L  = $clog2(N);
  localparam int unsigned S  = (L + 1) / 2;
  localparam int unsigned IW = L;
  localparam logic [N-1:0] LoMask = N'((64'd1 << K) - 64'd1);

  // One sparse-tree level: nodes with bit lvl set absorb the top of the preceding block.
  function automatic logic [2*N-1:0] lf_level(input logic [N-1:0] g, input logic [N-1:0] p,
                                              input int unsigned lvl);
    logic [N-1:0]  go;
    logic [N-1:0]  po;
    logic [IW-1:0] j;
    go = g;
    po = p;
    for (int unsigned i = 0; i < N; i++) begin
      if (((i >> lvl) & 1) != 0) begin
        j     = IW'(((i >> lvl) << lvl) - 1);
        go[i] = g[i] | (p[i] & g[j]);
        po[i] = p[i] & p[j];
      end
    end
    return {go, po};
  endfunction

  logic adv;
  logic out_valid_q;
  logic [N-1:0] sum_q;
  logic cout_q;
  logic diff_q;

  assign adv       = out_ready | ~out_valid_q;
  assign in_ready  = adv & ~rst;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_diff  = diff_q;

  // Front half: pre-processing and the first S prefix levels for both trees.
  logic [N-1:0] p_a, or_a, ge_a, pe_a, gd_a, pd_a;

  always_comb begin
    p_a  = a ^ b;
    or_a = a | b;
    ge_a = a & b;
    pe_a = p_a;
    gd_a = a & b;
    pd_a = p_a;
    // Approx tree: the low segment only contributes g[K-1] as the carry seed.
    if (approx_en) begin
      gd_a = gd_a & ~(LoMask >> 1);
      pd_a = pd_a & ~LoMask;
    end
    for (int unsigned l = 0; l < S; l++) begin
      {ge_a, pe_a} = lf_level(ge_a, pe_a, l);
      {gd_a, pd_a} = lf_level(gd_a, pd_a, l);
    end
  end

  logic         valid_b, ap_b, cin_b;
  logic [N-1:0] p_b, or_b, ge_b, pe_b, gd_b, pd_b;

  if (PIPE_STAGES == 2) begin : g_mid
    logic         valid_q, ap_q, cin_q;
    logic [N-1:0] p_q, or_q, ge_q, pe_q, gd_q, pd_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        ap_q    <= 1'b0;
        cin_q   <= 1'b0;
        p_q     <= '0;
        or_q    <= '0;
        ge_q    <= '0;
        pe_q    <= '0;
        gd_q    <= '0;
        pd_q    <= '0;
      end else if (adv) begin
        valid_q <= in_valid;
        if (in_valid) begin
          ap_q  <= approx_en;
          cin_q <= cin;
          p_q   <= p_a;
          or_q  <= or_a;
          ge_q  <= ge_a;
          pe_q  <= pe_a;
          gd_q  <= gd_a;
          pd_q  <= pd_a;
        end
      end
    end

    assign valid_b = valid_q;
    assign ap_b    = ap_q;
    assign cin_b   = cin_q;
    assign p_b     = p_q;
    assign or_b    = or_q;
    assign ge_b    = ge_q;
    assign pe_b    = pe_q;
    assign gd_b    = gd_q;
    assign pd_b    = pd_q;
  end else begin : g_nomid
    assign valid_b = in_valid;
    assign ap_b    = approx_en;
    assign cin_b   = cin;
    assign p_b     = p_a;
    assign or_b    = or_a;
    assign ge_b    = ge_a;
    assign pe_b    = pe_a;
    assign gd_b    = gd_a;
    assign pd_b    = pd_a;
  end

  // Back half: remaining levels, carries, sums and the mismatch flag.
  logic [N-1:0] ge_c, pe_c, gd_c, pd_c, sum_e, sum_d;
  logic [N:0]   c_e, c_d;
  logic         diff_d;

  always_comb begin
    ge_c = ge_b;
    pe_c = pe_b;
    gd_c = gd_b;
    pd_c = pd_b;
    for (int unsigned l = S; l < L; l++) begin
      {ge_c, pe_c} = lf_level(ge_c, pe_c, l);
      {gd_c, pd_c} = lf_level(gd_c, pd_c, l);
    end
    c_e   = {ge_c | (pe_c & {N{cin_b}}), cin_b};
    c_d   = {gd_c | (pd_c & {N{cin_b}}), cin_b};
    sum_e = p_b ^ c_e[N-1:0];
    sum_d = p_b ^ c_d[N-1:0];
    if (ap_b) begin
      sum_d = (sum_d & ~LoMask) | (or_b & LoMask);
    end
    diff_d = ({c_d[N], sum_d} != {c_e[N], sum_e});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      diff_q      <= 1'b0;
    end else if (adv) begin
      out_valid_q <= valid_b;
      if (valid_b) begin
        sum_q  <= sum_d;
        cout_q <= c_d[N];
        diff_q <= diff_d;
      end
    end
  end

endmodule

// File: tb/tb_lf_adder_pipe.sv
// Directed plus randomised bench for lf_adder_pipe; arithmetic model feeds a result queue.
module tb_lf_adder_pipe;

  localparam int unsigned N           = 16;
  localparam int unsigned K           = 4;
  localparam int unsigned PIPE_STAGES = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         approx_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         cout;
  logic         out_diff;

  int checks   = 0;
  int failures = 0;

  logic [N+1:0] sb[$];
  logic [N+1:0] exp_v;

  lf_adder_pipe #(
    .N          (N),
    .K          (K),
    .PIPE_STAGES(PIPE_STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .out_diff (out_diff)
  );

  always #5 clk = ~clk;

  // Returns {diff, cout, sum} computed with plain arithmetic.
  function automatic logic [N+1:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic ci, input logic ap);
    logic [N:0] ex, hi, lo_mask, res;
    ex  = {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, ci};
    res = ex;
    if (ap && K > 0) begin
      lo_mask = ({{N{1'b0}}, 1'b1} << K) - 1'b1;
      hi  = ({1'b0, av} >> K) + ({1'b0, bv} >> K) + {{N{1'b0}}, av[K-1] & bv[K-1]};
      res = (hi << K) | ({1'b0, av | bv} & lo_mask);
    end
    return {res != ex, res};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [N-1:0] av, input logic [N-1:0] bv, input logic ci,
                      input logic ap, input bit rnd);
    int n;
    bit done;
    n         = 0;
    done      = 1'b0;
    a         = av;
    b         = bv;
    cin       = ci;
    approx_en = ap;
    in_valid  = 1'b1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (done) begin
        sb.push_back(model(av, bv, ci, ap));
      end else begin
        n++;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        if (n > 200) begin
          check("send_timeout", 64'(in_ready), 64'd1);
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [N-1:0] s, input logic co,
                            input logic d);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        check(tag, 64'({out_diff, cout, sum}), 64'({d, co, s}));
      end
    end
    if (!found) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(out_valid), 64'd0);
      end else begin
        exp_v = sb.pop_front();
        check("result", 64'({out_diff, cout, sum}), 64'(exp_v));
      end
    end
  end

  initial begin
    logic [N+2:0] snap;
    int w;

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_data", 64'({out_diff, cout, sum}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a stream: in-flight beats must vanish.
    for (int i = 0; i < 3; i++) send(N'($urandom), N'($urandom), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'({out_diff, cout, sum}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Latency of a single exact beat.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= PIPE_STAGES; i++) begin
      @(negedge clk);
      check("latency_valid", 64'(out_valid), 64'(i == PIPE_STAGES));
      if (i == PIPE_STAGES) check("latency_data", 64'({out_diff, cout, sum}), 64'h0_0100);
      @(posedge clk);
      #1;
    end

    send(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
    expect_out("approx_err", 16'h00FF, 1'b0, 1'b1);
    send(16'h00FF, 16'h0001, 1'b1, 1'b1, 1'b0);
    expect_out("approx_cin_ignored", 16'h00FF, 1'b0, 1'b1);
    send(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
    expect_out("approx_match", 16'h5555, 1'b0, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    expect_out("wrap_b", 16'h0000, 1'b1, 1'b0);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    expect_out("wrap_cin", 16'h0000, 1'b1, 1'b0);

    // Backpressure: 8 beats, alternating mode, 3-cycle stall after the fourth.
    for (int i = 0; i < 4; i++) send(N'($urandom), N'($urandom), 1'b1, 1'(i & 1), 1'b0);
    out_ready = 1'b0;
    a         = 16'hA5A5;
    b         = 16'h5A5F;
    cin       = 1'b1;
    approx_en = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    snap = {out_valid, out_diff, cout, sum};
    check("stall_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", 64'({out_valid, out_diff, cout, sum}), 64'(snap));
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(16'hA5A5, 16'h5A5F, 1'b1, 1'b0, 1'b0);
    for (int i = 5; i < 8; i++) send(N'($urandom), N'($urandom), 1'b0, 1'(i & 1), 1'b0);

    // Random beats with random backpressure and idle gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'b1);
    end

    out_ready = 1'b1;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
